// File: rtl/spi_pkg.sv
// Shared definitions for the SPI register file: FSM states, R/W encoding
// and the frame width derivation used by the top level and the bench.
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_DATA,
    ST_DONE
  } spi_state_e;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  // One R/W bit, then the address field, then the data field.
  function automatic int frame_width(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction

endpackage

// File: rtl/spi_sync.sv
// Parameterised-width 2-flop synchroniser with edge detection.
// A third flop holds the previous synchronised value so that rise and fall
// are single clk pulses in the clk domain.
module spi_sync #(
  parameter int             W         = 1,
  parameter logic [W-1:0]   RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] async_in,
  output logic [W-1:0] sync,
  output logic [W-1:0] rise,
  output logic [W-1:0] fall
);

  logic [W-1:0] meta;
  logic [W-1:0] stage2;
  logic [W-1:0] stage3;

  // Two metastability flops followed by the history flop for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta   <= RESET_VAL;
      stage2 <= RESET_VAL;
      stage3 <= RESET_VAL;
    end else begin
      meta   <= async_in;
      stage2 <= meta;
      stage3 <= stage2;
    end
  end

  assign sync = stage2;
  assign rise = stage2 & ~stage3;
  assign fall = ~stage2 & stage3;

endmodule

// File: rtl/spi_regfile.sv
// SPI mode-0 slave register file. Frames are R/W bit, address, data, MSB
// first. Optional readback on cipo is compiled in with SPI_REG_READ_EN.
module spi_regfile
  import spi_pkg::*;
#(
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       sclk,
  input  logic                       ncs,
  input  logic                       copi,
  output logic                       cipo,
  output logic [NUM_REGS*DATA_W-1:0] regs_out,
  output logic [NUM_REGS-1:0]        wr_strobe,
  output logic                       frame_err
);

  localparam int FRAME_W = frame_width(ADDR_W, DATA_W);
  localparam int CNT_W   = $clog2(FRAME_W + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_W + 1);
  localparam logic [CNT_W-1:0] CNT_HDR  = CNT_W'(ADDR_W);

  logic [2:0] sync_v;
  logic [2:0] rise_v;
  logic [2:0] fall_v;

  // ncs resets high so the bus looks idle while rst_n is asserted.
  spi_sync #(.W(3), .RESET_VAL(3'b010)) u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in ({sclk, ncs, copi}),
    .sync     (sync_v),
    .rise     (rise_v),
    .fall     (fall_v)
  );

  logic ncs_s, copi_s, sclk_rise, ncs_rise, ncs_fall, sample;
  assign ncs_s     = sync_v[1];
  assign copi_s    = sync_v[0];
  assign sclk_rise = rise_v[2];
  assign ncs_rise  = rise_v[1];
  assign ncs_fall  = fall_v[1];
  assign sample    = sclk_rise && !ncs_s;

  logic unused_sync;
  assign unused_sync = ^{sync_v[2], rise_v[0], fall_v[0], fall_v[2]};

  logic [1:0] settle_cnt;
  logic       armed;

  // After reset the synchroniser flushes its forced-high ncs; a frame that was
  // already running would look like a fresh ncs fall, so frames are only
  // accepted once ncs has been genuinely seen high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_cnt <= '0;
      armed      <= 1'b0;
    end else begin
      if (settle_cnt != 2'd3) settle_cnt <= settle_cnt + 2'd1;
      if (settle_cnt == 2'd3 && ncs_s) armed <= 1'b1;
    end
  end

  spi_state_e                 state;
  logic [CNT_W-1:0]           bit_cnt;
  logic [FRAME_W-1:0]         shift_q;
  logic [NUM_REGS*DATA_W-1:0] regs_q;
  logic [NUM_REGS-1:0]        strobe_q;
  logic                       err_q;

  logic              cmd_rw;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_data;
  logic              addr_ok;
  assign cmd_rw   = shift_q[FRAME_W-1];
  assign cmd_addr = shift_q[DATA_W +: ADDR_W];
  assign cmd_data = shift_q[DATA_W-1:0];
  assign addr_ok  = int'(cmd_addr) < NUM_REGS;

  // Frame FSM: bit capture, frame validation and the register commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      bit_cnt  <= '0;
      shift_q  <= '0;
      regs_q   <= '0;
      strobe_q <= '0;
      err_q    <= 1'b0;
    end else begin
      strobe_q <= '0;
      err_q    <= 1'b0;
      if (ncs_rise) begin
        err_q <= (bit_cnt != '0) && (bit_cnt != CNT_FULL);
        state <= (state == ST_DATA) ? ST_DONE : ST_IDLE;
      end else if (ncs_fall && armed) begin
        state   <= ST_CMD;
        bit_cnt <= '0;
        shift_q <= '0;
      end else begin
        case (state)
          ST_CMD, ST_DATA: begin
            if (sample) begin
              shift_q <= {shift_q[FRAME_W-2:0], copi_s};
              if (bit_cnt != CNT_SAT) bit_cnt <= bit_cnt + CNT_W'(1);
              if (state == ST_CMD && bit_cnt == CNT_HDR) state <= ST_DATA;
            end
          end
          ST_DONE: begin
            if (bit_cnt == CNT_FULL && cmd_rw == RW_WRITE && addr_ok) begin
              regs_q[int'(cmd_addr)*DATA_W +: DATA_W] <= cmd_data;
              strobe_q <= NUM_REGS'(1) << cmd_addr;
            end
            state <= ST_IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  assign regs_out  = regs_q;
  assign wr_strobe = strobe_q;
  assign frame_err = err_q;

`ifdef SPI_REG_READ_EN
  logic [ADDR_W:0]   hdr_next;
  logic [ADDR_W-1:0] hdr_addr;
  logic              hdr_done;
  logic [DATA_W-1:0] rd_value;
  logic [DATA_W-1:0] rd_sh;
  logic              cipo_q;

  assign hdr_next = {shift_q[ADDR_W-1:0], copi_s};
  assign hdr_addr = hdr_next[ADDR_W-1:0];
  assign hdr_done = (state == ST_CMD) && sample && (bit_cnt == CNT_HDR) && !ncs_fall;

  // Read mux: out-of-range addresses read as zero.
  always_comb begin
    rd_value = '0;
    if (int'(hdr_addr) < NUM_REGS) rd_value = regs_q[int'(hdr_addr)*DATA_W +: DATA_W];
  end

  // Load at the end of the header, then present one bit per sclk fall so the
  // MSB is stable before the first data rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_sh  <= '0;
      cipo_q <= 1'b0;
    end else if (ncs_rise || ncs_fall) begin
      rd_sh  <= '0;
      cipo_q <= 1'b0;
    end else if (hdr_done) begin
      rd_sh  <= (hdr_next[ADDR_W] == RW_READ) ? rd_value : '0;
      cipo_q <= 1'b0;
    end else if (state == ST_DATA && fall_v[2] && !ncs_s) begin
      cipo_q <= rd_sh[DATA_W-1];
      rd_sh  <= rd_sh << 1;
    end
  end

  assign cipo = cipo_q;
`else
  assign cipo = 1'b0;
`endif

endmodule

// File: tb/tb_spi_regfile.sv
// Self-checking bench for spi_regfile: behavioural register model, event
// scoreboard for wr_strobe/frame_err, randomized frames plus directed cases.
`timescale 1ns/1ps
module tb_spi_regfile;

  localparam int NR = 8;
  localparam int AW = 7;
  localparam int DW = 8;
  localparam int FW = 1 + AW + DW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sclk = 1'b0, ncs = 1'b1, copi = 1'b0;
  logic cipo;
  logic [NR*DW-1:0] regs_out;
  logic [NR-1:0] wr_strobe;
  logic frame_err;

  logic sclk2 = 1'b0, ncs2 = 1'b1, copi2 = 1'b0;
  logic cipo2;
  logic [255:0] regs_out2;
  logic [15:0] wr_strobe2;
  logic frame_err2;

  spi_regfile dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .ncs(ncs), .copi(copi), .cipo(cipo),
    .regs_out(regs_out), .wr_strobe(wr_strobe), .frame_err(frame_err)
  );

  spi_regfile #(.NUM_REGS(16), .ADDR_W(4), .DATA_W(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .sclk(sclk2), .ncs(ncs2), .copi(copi2), .cipo(cipo2),
    .regs_out(regs_out2), .wr_strobe(wr_strobe2), .frame_err(frame_err2)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_err;
    int         addr;
    logic [7:0] data;
  } event_t;

  int assertions = 0;
  int failures = 0;
  event_t exp_q[$];
  logic [7:0] model_regs [NR];
  logic [NR-1:0] last_strobe = '0;
  int err_seen = 0;
  bit checking = 1'b0;
  event_t cmp_ev;
  bit head_ok;
  logic [15:0] strobe2_seen = '0;
  int strobe2_count = 0;
  int err2_count = 0;

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    assertions++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [NR*DW-1:0] modelFlat();
    logic [NR*DW-1:0] f;
    f = '0;
    for (int i = 0; i < NR; i++) f[i*DW +: DW] = model_regs[i];
    return f;
  endfunction

  function automatic logic [63:0] mkFrame(input logic rw, input logic [6:0] addr, input logic [7:0] data);
    return {48'b0, rw, addr, data};
  endfunction

  // Every clk: strobes and errors must match the scoreboard head, and the
  // register outputs must match the model.
  always @(negedge clk) begin
    if (checking && rst_n) begin
      if (wr_strobe != '0) begin
        head_ok = (exp_q.size() > 0) && !exp_q[0].is_err;
        if (!head_ok) checkOutput("unexpected wr_strobe", wr_strobe, '0);
        else begin
          cmp_ev = exp_q.pop_front();
          checkOutput("wr_strobe", wr_strobe, NR'(1) << cmp_ev.addr);
          model_regs[cmp_ev.addr] = cmp_ev.data;
          last_strobe = wr_strobe;
        end
      end
      if (frame_err) begin
        head_ok = (exp_q.size() > 0) && exp_q[0].is_err;
        checkOutput("frame_err expected", head_ok, 1'b1);
        if (head_ok) begin
          void'(exp_q.pop_front());
          err_seen++;
        end
      end
      checkOutput("regs_out", regs_out, modelFlat());
    end
  end

  // Observation of the wide instance.
  always @(negedge clk) begin
    if (rst_n && wr_strobe2 != '0) begin
      strobe2_seen = wr_strobe2;
      strobe2_count++;
    end
    if (rst_n && frame_err2) err2_count++;
  end

  task automatic spiBit(input int which, input logic b, output logic s);
    if (which == 0) copi = b; else copi2 = b;
    #49;
    s = (which == 0) ? cipo : cipo2;
    #1;
    if (which == 0) sclk = 1'b1; else sclk2 = 1'b1;
    #50;
    if (which == 0) sclk = 1'b0; else sclk2 = 1'b0;
  endtask

  task automatic applyStimulus(input int which, input logic [63:0] bits, input int n, output logic [63:0] cap);
    logic s;
    cap = '0;
    if (which == 0) ncs = 1'b0; else ncs2 = 1'b0;
    #50;
    for (int i = n - 1; i >= 0; i--) begin
      spiBit(which, bits[i], s);
      cap = {cap[62:0], s};
    end
    #50;
    if (which == 0) begin ncs = 1'b1; copi = 1'b0; end
    else begin ncs2 = 1'b1; copi2 = 1'b0; end
    #100;
  endtask

  task automatic waitDrain();
    int n = 0;
    event_t ev;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    checkOutput("events drained", exp_q.size(), 0);
    while (exp_q.size() != 0) begin
      ev = exp_q.pop_front();
      if (!ev.is_err) model_regs[ev.addr] = ev.data;
    end
  endtask

  task automatic doFrame(input logic [63:0] bits, input int n, output logic [7:0] rdval);
    logic [63:0] cap;
    logic [63:0] exp_cap;
    event_t ev;
    int addr;
    exp_cap = '0;
    if (n == FW) begin
      addr = int'(bits[14:8]);
      if (bits[15] && addr < NR) begin
        ev.is_err = 1'b0; ev.addr = addr; ev.data = bits[7:0];
        exp_q.push_back(ev);
      end
`ifdef SPI_REG_READ_EN
      if (!bits[15] && addr < NR) exp_cap = {56'b0, model_regs[addr]};
`endif
    end else if (n != 0) begin
      ev.is_err = 1'b1; ev.addr = 0; ev.data = '0;
      exp_q.push_back(ev);
    end
    applyStimulus(0, bits, n, cap);
    if (n == FW) checkOutput("cipo stream", cap[15:0], exp_cap[15:0]);
    rdval = cap[7:0];
    waitDrain();
  endtask

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] rd;
    logic [63:0] frm;
    logic [63:0] cap;
    logic s;
    int e0;
    int kind;
    int n;

    for (int i = 0; i < NR; i++) model_regs[i] = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset regs_out", regs_out, '0);
    checkOutput("reset wr_strobe", wr_strobe, '0);
    checkOutput("reset frame_err", frame_err, 1'b0);
    checkOutput("reset cipo", cipo, 1'b0);
    checkOutput("reset regs_out2", regs_out2, '0);
    rst_n = 1'b1;
    checking = 1'b1;
    repeat (6) @(negedge clk);

    $display("[TB] basic write to register 3");
    doFrame(mkFrame(1'b1, 7'd3, 8'hA5), FW, rd);
    checkOutput("reg3 value", regs_out[31:24], 8'hA5);
    checkOutput("reg3 strobe", last_strobe, 8'h08);
    checkOutput("other regs", {regs_out[63:32], regs_out[23:0]}, '0);

    $display("[TB] short, long and very long frames");
    e0 = err_seen;
    doFrame({$urandom, $urandom}, 15, rd);
    doFrame({$urandom, $urandom}, 17, rd);
    checkOutput("short/long err count", err_seen - e0, 2);
    doFrame({16'hFFFF, 48'h8355_AAAA_AAAA}, 48, rd);
    checkOutput("saturated err count", err_seen - e0, 3);
    checkOutput("regs after bad frames", regs_out, 64'h0000_0000_A500_0000);

    $display("[TB] out-of-range write");
    e0 = err_seen;
    doFrame(mkFrame(1'b1, 7'h10, 8'h5A), FW, rd);
    checkOutput("oor regs", regs_out, 64'h0000_0000_A500_0000);
    checkOutput("oor no err", err_seen - e0, 0);

    $display("[TB] readback of register 5");
    doFrame(mkFrame(1'b1, 7'd5, 8'h3C), FW, rd);
    doFrame(mkFrame(1'b0, 7'd5, 8'h77), FW, rd);
`ifdef SPI_REG_READ_EN
    checkOutput("readback reg5", rd, 8'h3C);
`else
    checkOutput("readback disabled", rd, 8'h00);
`endif
    checkOutput("reg5 after read", regs_out[47:40], 8'h3C);

    $display("[TB] randomized frames");
    for (int f = 0; f < 40; f++) begin
      kind = $urandom_range(0, 9);
      frm = {$urandom, $urandom};
      n = FW;
      if (kind <= 4) begin
        frm[15] = 1'b1; frm[14:8] = 7'($urandom_range(0, NR - 1));
      end else if (kind == 5) begin
        frm[15] = 1'b1; frm[14:8] = 7'($urandom_range(NR, 127));
      end else if (kind == 6) begin
        n = $urandom_range(1, FW - 1);
      end else if (kind == 7) begin
        n = $urandom_range(FW + 1, FW + 8);
      end else begin
        frm[15] = 1'b0; frm[14:8] = 7'($urandom_range(0, NR + 1));
      end
      doFrame(frm, n, rd);
    end

    $display("[TB] reset in the middle of a frame");
    frm = mkFrame(1'b1, 7'd2, 8'h99);
    e0 = err_seen;
    ncs = 1'b0;
    #50;
    for (int i = FW - 1; i >= 6; i--) spiBit(0, frm[i], s);
    @(posedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < NR; i++) model_regs[i] = '0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    checkOutput("regs during reset", regs_out, '0);
    checkOutput("strobe during reset", wr_strobe, '0);
    checkOutput("cipo during reset", cipo, 1'b0);
    rst_n = 1'b1;
    for (int i = 5; i >= 0; i--) spiBit(0, frm[i], s);
    #50;
    ncs = 1'b1;
    copi = 1'b0;
    #100;
    waitDrain();
    checkOutput("dropped frame no err", err_seen - e0, 0);
    checkOutput("dropped frame regs", regs_out, '0);
    doFrame(mkFrame(1'b1, 7'd6, 8'hC3), FW, rd);
    checkOutput("write after reset", regs_out, 64'h00C3_0000_0000_0000);

    $display("[TB] wide instance write");
    applyStimulus(1, {43'b0, 1'b1, 4'hF, 16'hBEEF}, 21, cap);
    repeat (5) @(negedge clk);
    checkOutput("dut16 strobe", strobe2_seen, 16'h8000);
    checkOutput("dut16 strobe count", strobe2_count, 1);
    checkOutput("dut16 reg15", regs_out2[255:240], 16'hBEEF);
    checkOutput("dut16 other regs", regs_out2[239:0], '0);
    checkOutput("dut16 no err", err2_count, 0);

    checking = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule

// File: doc/spi_regfile.md
SPI_REGFILE -- requirements
Module: spi_regfile

Interface
REQ-001 SHALL have parameter NUM_REGS, default 8, number of DATA_W-bit registers (1..2**ADDR_W).
REQ-002 SHALL have parameter ADDR_W, default 7, address field width.
REQ-003 SHALL have parameter DATA_W, default 8, register and data field width.
REQ-004 SHALL have port clk  input  1  system clock; the only clock.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port sclk  input  1  SPI clock, asynchronous to clk.
REQ-007 SHALL have port ncs  input  1  SPI chip select, active low, asynchronous.
REQ-008 SHALL have port copi  input  1  SPI controller-out data, asynchronous.
REQ-009 SHALL have port cipo  output  1  SPI controller-in data.
REQ-010 SHALL have port regs_out  output  NUM_REGS*DATA_W  flattened register contents; register i occupies bits [i*DATA_W +: DATA_W].
REQ-011 SHALL have port wr_strobe  output  NUM_REGS  one-cycle pulse on bit i when register i is written.
REQ-012 SHALL have port frame_err  output  1  one-cycle pulse on a malformed frame.

Function
REQ-013 SHALL pass sclk, ncs and copi through 2-flop synchronisers; edges are detected against a third flop.
REQ-014 SHALL use SPI mode 0 framing, MSB first, FRAME_W = 1+ADDR_W+DATA_W bits: R/W bit (1=write), address, data.
REQ-015 SHALL sample copi on each synchronised sclk rising edge while synchronised ncs is low.
REQ-016 SHALL implement FSM IDLE -> CMD on ncs fall; CMD -> DATA after 1+ADDR_W bits; DATA -> DONE on ncs rise; any state -> IDLE on ncs rise; DONE -> IDLE after one clk.
REQ-017 SHALL, in DONE, commit a write only if exactly FRAME_W bits were received, R/W=1 and address < NUM_REGS.
REQ-018 SHALL update the register and pulse its wr_strobe bit in the same clk edge, one clk after DONE is entered.
REQ-019 SHALL ignore writes to address >= NUM_REGS with no strobe and no frame_err.
REQ-020 SHALL pulse frame_err for one clk and discard the frame when the bit count at ncs rise is nonzero and not FRAME_W; a saturating bit counter prevents wrap on over-length frames.
REQ-021 SHALL treat a new ncs fall as a fresh frame that clears the bit counter and shift register.
REQ-022 SHALL hold cipo at 0 whenever ncs is high or readback is not compiled in.

Reset
REQ-023 SHALL, while rst_n is low, force all registers to 0, wr_strobe to 0, frame_err to 0, cipo to 0, FSM to IDLE and synchronised ncs to 1.
REQ-024 SHALL drop a frame that is in progress when reset asserts; no write commits, and the first frame after release starts on the next ncs fall.

Configuration
REQ-025 SHALL compile readback in only when SPI_REG_READ_EN is defined.
REQ-026 With SPI_REG_READ_EN, a frame with R/W=0 SHALL load the addressed register at CMD->DATA, or 0 if address >= NUM_REGS.
REQ-027 With SPI_REG_READ_EN, the loaded value SHALL be driven on cipo MSB first, changing on each synchronised sclk falling edge in DATA.
REQ-028 With SPI_REG_READ_EN, read frames SHALL never modify registers.
REQ-029 Without SPI_REG_READ_EN, R/W=0 frames SHALL be accepted and ignored, cipo SHALL be constant 0, and no read mux is synthesised.

Structure
REQ-030 SHALL place the FSM state enum, the R/W bit encoding and the FRAME_W derivation function in shared package spi_pkg.
REQ-031 SHALL use sub-module spi_sync (parameterised-width 2-flop synchroniser with edge detect), instantiated once for {sclk, ncs, copi}.

Verification
REQ-032 Reset/default: assert rst_n=0 mid-frame, release -> regs_out=0, no wr_strobe, next full write frame commits normally.
REQ-033 Write: defaults, frame 1_0000011_10100101 -> register 3=0xA5, wr_strobe=8'b0000_1000 for one clk, other registers unchanged.
REQ-034 Short/long frame: 15 bits, then 17 bits -> one frame_err pulse each, no register change.
REQ-035 Out of range: write to address 0x10 with NUM_REGS=8 -> no strobe, no frame_err, regs_out unchanged.
REQ-036 Readback (SPI_REG_READ_EN): preload register 5=0x3C, send read frame 0_0000101_xxxxxxxx -> cipo shifts 0,0,1,1,1,1,0,0 and register 5 is unchanged.
REQ-037 Parametric: NUM_REGS=16, DATA_W=16, ADDR_W=4 -> write 0xBEEF to address 15 gives regs_out[255:240]=0xBEEF.
